// File: rtl/comp_serial_ctrl_pkg.sv
// Shared types and constants for the serial magnitude comparator:
// FSM state encoding, one-hot {l,e,g} result codes and the 2x1 mux primitive.
package comp_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;

  // Result is carried as {l, e, g}; exactly one bit set after a done.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

  function automatic logic mux2(input logic sel, input logic d0, input logic d1);
    return sel ? d1 : d0;
  endfunction

endpackage

// File: rtl/comp_bit_slice.sv
// One-bit magnitude comparator slice built from 2x1 muxes selected by ai.
module comp_bit_slice
  import comp_serial_ctrl_pkg::*;
(
  input  logic ai,
  input  logic bi,
  output logic lt,
  output logic eq,
  output logic gt
);

  // With ai as select: ai=0 -> lt=bi, gt=0; ai=1 -> lt=0, gt=~bi.
  assign lt = mux2(ai, bi,    1'b0);
  assign eq = mux2(ai, ~bi,   bi);
  assign gt = mux2(ai, 1'b0,  ~bi);

endmodule

// File: rtl/comp_serial_ctrl.sv
// Serial MSB-first magnitude comparator sequencer: walks one comparator slice
// down the captured operands and stops at the first differing bit.
module comp_serial_ctrl
  import comp_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [2:0]       res_q, res_nxt;
  logic             done_q, done_nxt;

  logic bit_a, bit_b;
  logic s_lt, s_eq, s_gt;

  assign bit_a = a_q[idx];
  assign bit_b = b_q[idx];

  comp_bit_slice u_slice (
    .ai (bit_a),
    .bi (bit_b),
    .lt (s_lt),
    .eq (s_eq),
    .gt (s_gt)
  );

  // NOTE: every signal gets its hold/default value first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    idx_nxt   = idx;
    res_nxt   = res_q;
    done_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        // start wins over abort here; abort has no meaning outside RUN.
        if (start) begin
          a_nxt     = a;
          b_nxt     = b;
          idx_nxt   = IDX_TOP;
          res_nxt   = RES_NONE;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!s_eq) begin
          res_nxt   = s_lt ? RES_LT : RES_GT;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (idx == '0) begin
          res_nxt   = RES_EQ;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      res_q  <= RES_NONE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      idx    <= idx_nxt;
      res_q  <= res_nxt;
      done_q <= done_nxt;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = done_q;
  assign l    = res_q[2];
  assign e    = res_q[1];
  assign g    = res_q[0];

  // s_gt is implied by !s_eq && !s_lt; kept connected for slice completeness.
  logic unused_gt;
  assign unused_gt = s_gt;

endmodule
